// File: rtl/mtr_pwm_drv.sv
// mtr_pwm_drv: motor-drive PWM stage for a left and a right H-bridge.
//
// The stage converts the signed left/right speed commands into complementary,
// non-overlapping gate pairs on a shared 2048-clock PWM period. It also blanks
// and filters the driver over-current flags, and latches a shutdown that holds
// every gate low once enough consecutive periods have seen over-current.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous reset, active high
//   lft_spd      in   [11:0] signed left speed command
//   rght_spd     in   [11:0] signed right speed command
//   OVR_I_lft    in   left driver over-current flag (asynchronous)
//   OVR_I_rght   in   right driver over-current flag (asynchronous)
//   lft_PWM1     out  left reverse gate drive
//   lft_PWM2     out  left forward gate drive
//   rght_PWM1    out  right reverse gate drive
//   rght_PWM2    out  right forward gate drive
//   PWM_synch    out  one-clock pulse at the start of each PWM period
//   OVR_I_shtdwn out  latched over-current shutdown (cleared only by rst)
module mtr_pwm_drv #(
    parameter logic [10:0] NONOVERLAP  = 11'h020,
    parameter logic [7:0]  BLANK_CYC   = 8'd40,
    parameter logic [3:0]  OVR_I_LIMIT = 4'd10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] lft_spd,
    input  logic [11:0] rght_spd,
    input  logic        OVR_I_lft,
    input  logic        OVR_I_rght,
    output logic        lft_PWM1,
    output logic        lft_PWM2,
    output logic        rght_PWM1,
    output logic        rght_PWM2,
    output logic        PWM_synch,
    output logic        OVR_I_shtdwn
);

    logic [10:0] r_cnt;
    logic        r_synch;
    logic [10:0] r_lft_duty;
    logic [10:0] r_rght_duty;
    logic        r_lft_pwm1;
    logic        r_lft_pwm2;
    logic        r_rght_pwm1;
    logic        r_rght_pwm2;
    logic        r_lft_pwm1_d;
    logic        r_lft_pwm2_d;
    logic        r_rght_pwm1_d;
    logic        r_rght_pwm2_d;
    logic        r_ovr_lft_s1;
    logic        r_ovr_lft_s2;
    logic        r_ovr_rght_s1;
    logic        r_ovr_rght_s2;
    logic [7:0]  r_lft_blank;
    logic [7:0]  r_rght_blank;
    logic        r_ovr_seen;
    logic [3:0]  r_ovr_cnt;
    logic        r_shtdwn;

    logic        w_period_end;
    logic [10:0] w_lft_duty_nxt;
    logic [10:0] w_rght_duty_nxt;
    logic [11:0] w_lft_thr1;
    logic [11:0] w_rght_thr1;
    logic        w_lft_on1;
    logic        w_lft_on2;
    logic        w_rght_on1;
    logic        w_rght_on2;
    logic        w_lft_edge;
    logic        w_rght_edge;
    logic        w_lft_valid;
    logic        w_rght_valid;
    logic [3:0]  w_ovr_cnt_inc;

    // Clip to -1024..1023 then offset by +1024; inside the clip range the
    // offset is just an inversion of bit 10 of the two's-complement value.
    function automatic logic [10:0] f_spd2duty(input logic [11:0] spd);
        if ($signed(spd) > 12'sd1023)
            return 11'h7FF;
        else if ($signed(spd) < -12'sd1024)
            return 11'h000;
        else
            return {~spd[10], spd[9:0]};
    endfunction

    assign w_period_end    = (r_cnt == 11'h7FF);
    assign w_lft_duty_nxt  = f_spd2duty(lft_spd);
    assign w_rght_duty_nxt = f_spd2duty(rght_spd);

    // 12-bit threshold: a sum above 2047 is unreachable, so PWM1 stays off.
    assign w_lft_thr1  = {1'b0, r_lft_duty}  + {1'b0, NONOVERLAP};
    assign w_rght_thr1 = {1'b0, r_rght_duty} + {1'b0, NONOVERLAP};

    assign w_lft_on2  = (r_cnt >= NONOVERLAP) && (r_cnt < r_lft_duty);
    assign w_lft_on1  = ({1'b0, r_cnt} >= w_lft_thr1);
    assign w_rght_on2 = (r_cnt >= NONOVERLAP) && (r_cnt < r_rght_duty);
    assign w_rght_on1 = ({1'b0, r_cnt} >= w_rght_thr1);

    assign w_lft_edge  = (r_lft_pwm1 ^ r_lft_pwm1_d) | (r_lft_pwm2 ^ r_lft_pwm2_d);
    assign w_rght_edge = (r_rght_pwm1 ^ r_rght_pwm1_d) | (r_rght_pwm2 ^ r_rght_pwm2_d);

    assign w_lft_valid  = (r_lft_pwm1 | r_lft_pwm2) && (r_lft_blank >= BLANK_CYC)
                          && r_ovr_lft_s2;
    assign w_rght_valid = (r_rght_pwm1 | r_rght_pwm2) && (r_rght_blank >= BLANK_CYC)
                          && r_ovr_rght_s2;

    assign w_ovr_cnt_inc = (r_ovr_cnt == 4'hF) ? 4'hF : r_ovr_cnt + 4'd1;

    // Period counter, start-of-period pulse and duty latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_synch     <= 1'b0;
            r_lft_duty  <= 11'h400;
            r_rght_duty <= 11'h400;
        end else begin
            r_cnt   <= r_cnt + 11'd1;
            r_synch <= (r_cnt == 11'd0);
            if (w_period_end) begin
                r_lft_duty  <= w_lft_duty_nxt;
                r_rght_duty <= w_rght_duty_nxt;
            end
        end
    end

    // Registered gate compare; shutdown overrides all gates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lft_pwm1  <= 1'b0;
            r_lft_pwm2  <= 1'b0;
            r_rght_pwm1 <= 1'b0;
            r_rght_pwm2 <= 1'b0;
        end else if (r_shtdwn) begin
            r_lft_pwm1  <= 1'b0;
            r_lft_pwm2  <= 1'b0;
            r_rght_pwm1 <= 1'b0;
            r_rght_pwm2 <= 1'b0;
        end else begin
            r_lft_pwm1  <= w_lft_on1;
            r_lft_pwm2  <= w_lft_on2;
            r_rght_pwm1 <= w_rght_on1;
            r_rght_pwm2 <= w_rght_on2;
        end
    end

    // Over-current synchronisers, gate-edge history and blanking counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovr_lft_s1  <= 1'b0;
            r_ovr_lft_s2  <= 1'b0;
            r_ovr_rght_s1 <= 1'b0;
            r_ovr_rght_s2 <= 1'b0;
            r_lft_pwm1_d  <= 1'b0;
            r_lft_pwm2_d  <= 1'b0;
            r_rght_pwm1_d <= 1'b0;
            r_rght_pwm2_d <= 1'b0;
            r_lft_blank   <= '0;
            r_rght_blank  <= '0;
        end else begin
            r_ovr_lft_s1  <= OVR_I_lft;
            r_ovr_lft_s2  <= r_ovr_lft_s1;
            r_ovr_rght_s1 <= OVR_I_rght;
            r_ovr_rght_s2 <= r_ovr_rght_s1;
            r_lft_pwm1_d  <= r_lft_pwm1;
            r_lft_pwm2_d  <= r_lft_pwm2;
            r_rght_pwm1_d <= r_rght_pwm1;
            r_rght_pwm2_d <= r_rght_pwm2;
            if (w_lft_edge)
                r_lft_blank <= '0;
            else if (r_lft_blank != 8'hFF)
                r_lft_blank <= r_lft_blank + 8'd1;
            if (w_rght_edge)
                r_rght_blank <= '0;
            else if (r_rght_blank != 8'hFF)
                r_rght_blank <= r_rght_blank + 8'd1;
        end
    end

    // Per-period over-current filter and sticky shutdown. A sample taken in
    // the period-end clock is dropped: the flag is cleared in that clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovr_seen <= 1'b0;
            r_ovr_cnt  <= '0;
            r_shtdwn   <= 1'b0;
        end else if (w_period_end) begin
            r_ovr_seen <= 1'b0;
            r_ovr_cnt  <= r_ovr_seen ? w_ovr_cnt_inc : 4'd0;
            if (r_ovr_seen && (w_ovr_cnt_inc >= OVR_I_LIMIT))
                r_shtdwn <= 1'b1;
        end else if (w_lft_valid || w_rght_valid) begin
            r_ovr_seen <= 1'b1;
        end
    end

    assign lft_PWM1     = r_lft_pwm1;
    assign lft_PWM2     = r_lft_pwm2;
    assign rght_PWM1    = r_rght_pwm1;
    assign rght_PWM2    = r_rght_pwm2;
    assign PWM_synch    = r_synch;
    assign OVR_I_shtdwn = r_shtdwn;

endmodule

// File: doc/mtr_pwm_drv.md
Name: mtr_pwm_drv

Overview:
Motor-drive PWM stage directly downstream of the balance/steer math block. It takes the saturated signed left/right speed commands and produces complementary, non-overlapping H-bridge gate signals, one pair per motor, on a shared 11-bit PWM period. It also blanks and filters the motor-driver over-current flags, and latches a shutdown that forces all gates low after a run of consecutive over-current periods.

Parameters:
NONOVERLAP, 11'h020, dead time in clocks inserted before each gate rises.
BLANK_CYC, 8'd40, clocks after any gate edge during which OVR_I is ignored.
OVR_I_LIMIT, 4'd10, consecutive PWM periods with over-current that trigger shutdown.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active high
lft_spd  in  12  signed left speed command
rght_spd  in  12  signed right speed command
OVR_I_lft  in  1  left driver over-current flag, asynchronous
OVR_I_rght  in  1  right driver over-current flag, asynchronous
lft_PWM1  out  1  left reverse gate drive
lft_PWM2  out  1  left forward gate drive
rght_PWM1  out  1  right reverse gate drive
rght_PWM2  out  1  right forward gate drive
PWM_synch  out  1  one-clock pulse at the start of each PWM period
OVR_I_shtdwn  out  1  latched over-current shutdown

Behaviour:
- Clocking: one clock domain (clk). rst is asynchronous and active high.
- Reset values: cnt=0, all four gate outputs 0, PWM_synch 0, OVR_I_shtdwn 0, latched duties 11'h400, consecutive-period counter 0, synchroniser flops 0, blank counters 0.
- Counter: cnt is 11 bits, free running, and wraps from 2047 to 0. The period is 2048 clocks. PWM_synch is registered and is high in the clock after cnt==0.
- Duty: clip each speed command to the range -1024..1023, then add 1024 to get an unsigned 11-bit duty. Both duties are latched only when cnt==2047. A speed change mid-period takes effect in the next period.
- Gate compare, registered (1 clock latency from cnt):
  - PWM2 = (cnt >= NONOVERLAP) && (cnt < duty).
  - PWM1 = (cnt >= duty + NONOVERLAP), where the sum is computed in 12 bits. If the sum exceeds 2047, PWM1 stays low for the whole period.
  - PWM1 and PWM2 are never high in the same clock, for any duty.
- OVR_I input path: each OVR_I input passes through a 2-flop synchroniser.
- Blank counter (8-bit, one per side):
  - clears on any edge of that side's PWM1 or PWM2;
  - otherwise increments, saturating at 255.
- A sample is valid when (PWM1|PWM2) && blank_cnt >= BLANK_CYC && the synchronised flag is 1. A valid sample on either side sets a per-period ovr_seen flag.
- Period end (cnt==2047):
  - if ovr_seen is set, increment the consecutive-period counter (saturating); otherwise clear it;
  - clear ovr_seen;
  - if the counter reaches OVR_I_LIMIT, set OVR_I_shtdwn.
- Shutdown:
  - OVR_I_shtdwn is sticky; only rst clears it.
  - While it is set, all gates are 0 from the next clock onward. cnt keeps running and PWM_synch keeps pulsing.
- Reset mid-period: all outputs drop to 0 immediately (asynchronous). After rst deasserts, cnt restarts at 0 with 50% duty until the first cnt==2047 latch.

Test Plan:
- lft_spd=0, sustained: lft_PWM2 high for 992 clocks (cnt 32..1023) and lft_PWM1 high for 992 clocks (cnt 1056..2047), with a 32-clock gap between them in each order.
- rght_spd=+1500: clipped to 1023, duty 2047. rght_PWM2 high for 2015 clocks per period; rght_PWM1 never asserts.
- lft_spd=12'h800 (-2048): duty 0. lft_PWM2 never asserts; lft_PWM1 high for 2016 clocks per period.
- lft_spd changes from 0 to 500 at cnt=300: the current period still ends PWM2 at cnt 1023. The next period ends PWM2 at cnt 1523. An assertion checks PWM1&PWM2 is never 1.
- OVR_I_lft held high: OVR_I_shtdwn asserts after the 10th period end and all gates stay 0. A glitch on OVR_I_lft inside the first 40 clocks after an edge is ignored. 9 bad periods followed by 1 clean period resets the count with no shutdown.
- Assert rst during shutdown, mid-period: outputs are 0 asynchronously. After release, PWM_synch is seen at cnt 0 and the gates resume at 50% duty.
